// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-sweep sequencer driving the DDS freq/synch inputs
module dds_sweep_ctrl #(
  parameter int FREQ_W  = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               repeat_en,
  output logic [FREQ_W-1:0]  freq,
  output logic               synch,
  output logic               busy,
  output logic               done
);

  localparam logic [DWELL_W-1:0] ONE_D = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t              state;
  logic [DWELL_W-1:0]  cnt;
  logic [FREQ_W-1:0]   s_start;
  logic [FREQ_W-1:0]   s_stop;
  logic [FREQ_W-1:0]   s_step;
  logic [DWELL_W-1:0]  s_dwell;
  logic                s_rep;
  logic                s_up;

  logic [FREQ_W:0]     sum;
  logic [FREQ_W:0]     diff;
  logic [FREQ_W-1:0]   nxt;
  logic [DWELL_W-1:0]  dwell_eff;

  // Next sweep point; the extra MSB catches carry/borrow so the sweep clamps on f_stop instead of wrapping
  always_comb begin
    sum  = {1'b0, freq} + {1'b0, s_step};
    diff = {1'b0, freq} - {1'b0, s_step};
    nxt  = s_stop;
    if (s_up) begin
      if (!(sum[FREQ_W] || (sum[FREQ_W-1:0] >= s_stop) || (s_step == '0)))
        nxt = sum[FREQ_W-1:0];
    end else begin
      if (!(diff[FREQ_W] || (diff[FREQ_W-1:0] <= s_stop) || (s_step == '0)))
        nxt = diff[FREQ_W-1:0];
    end
    dwell_eff = (dwell == '0) ? ONE_D : dwell;
  end

  // Sweep sequencer: snapshots config on start, steps freq every dwell_eff cycles, strobes synch on each change
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      freq    <= '0;
      synch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_start <= '0;
      s_stop  <= '0;
      s_step  <= '0;
      s_dwell <= '0;
      s_rep   <= 1'b0;
      s_up    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          synch <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start && !abort) begin
            s_start <= f_start;
            s_stop  <= f_stop;
            s_step  <= f_step;
            s_dwell <= dwell_eff;
            s_rep   <= repeat_en;
            s_up    <= (f_stop >= f_start);
            freq    <= f_start;
            synch   <= 1'b1;
            busy    <= 1'b1;
            cnt     <= dwell_eff - ONE_D;
            state   <= DWELL;
          end
        end
        DWELL: begin
          if (abort) begin
            state <= IDLE;
            freq  <= '0;
            synch <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (cnt != '0) begin
            cnt   <= cnt - ONE_D;
            synch <= 1'b0;
          end else if (freq != s_stop) begin
            freq  <= nxt;
            synch <= 1'b1;
            cnt   <= s_dwell - ONE_D;
          end else if (s_rep) begin
            freq  <= s_start;
            synch <= 1'b1;
            cnt   <= s_dwell - ONE_D;
          end else begin
            state <= DONE;
            synch <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          if (abort) begin
            freq  <= '0;
            synch <= 1'b1;
          end else begin
            synch <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          synch <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - randomized self-checking bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, repeat_en;
  logic [31:0] f_start, f_stop, f_step, freq;
  logic [15:0] dwell;
  logic        synch, busy, done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  longint      cur_freq = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FREQ_W(32), .DWELL_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .repeat_en(repeat_en), .freq(freq), .synch(synch), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {freq,synch,busy,done}=%h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input longint f, input bit s, input bit b, input bit d);
    logic [31:0] fw;
    fw = f[31:0];
    return {29'd0, fw, s, b, d};
  endfunction

  function automatic logic [63:0] obs_now();
    return {29'd0, freq, synch, busy, done};
  endfunction

  // Expected per-cycle trace from the point list: each point held dwell_eff cycles, synch on its first cycle
  task automatic build(input longint fs, input longint fe, input longint fp, input int dw,
                       input bit rep, input int ncyc);
    longint pts[$];
    longint p;
    int     dwe;
    pts.delete();
    exp_q.delete();
    p = fs;
    pts.push_back(p);
    while (p != fe) begin
      if (fe > fs) p = (fp == 0 || p + fp >= fe) ? fe : p + fp;
      else         p = (fp == 0 || p - fp <= fe) ? fe : p - fp;
      pts.push_back(p);
    end
    dwe = (dw == 0) ? 1 : dw;
    if (!rep) begin
      foreach (pts[i])
        for (int k = 0; k < dwe; k++) exp_q.push_back(pk(pts[i], k == 0, 1'b1, 1'b0));
      exp_q.push_back(pk(fe, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(pk(fe, 1'b0, 1'b0, 1'b0));
    end else begin
      for (int i = 0; exp_q.size() < ncyc; i++)
        for (int k = 0; k < dwe && exp_q.size() < ncyc; k++)
          exp_q.push_back(pk(pts[i % pts.size()], k == 0, 1'b1, 1'b0));
    end
  endtask

  task automatic noise();
    f_start   = $urandom;
    f_stop    = $urandom;
    f_step    = $urandom;
    dwell     = 16'($urandom);
    repeat_en = 1'($urandom);
    start     = 1'($urandom);
  endtask

  task automatic run(input string tag, input longint fs, input longint fe, input longint fp,
                     input int dw, input bit rep, input int ncyc, input int rst_at);
    build(fs, fe, fp, dw, rep, ncyc);
    @(negedge clk);
    f_start = fs[31:0]; f_stop = fe[31:0]; f_step = fp[31:0]; dwell = 16'(dw);
    repeat_en = rep; start = 1'b1; abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check({tag, "_reset"}, obs_now(), pk(0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        cur_freq = 0;
        return;
      end
      check(tag, obs_now(), exp_q[i]);
      if (i < exp_q.size() - 1) noise();
      else start = 1'b0;
    end
    if (rep) begin
      abort = 1'b1; start = 1'b0;
      @(negedge clk);
      check({tag, "_abort"}, obs_now(), pk(0, 1'b1, 1'b0, 1'b0));
      abort = 1'b0;
      @(negedge clk);
      check({tag, "_idle"}, obs_now(), pk(0, 1'b0, 1'b0, 1'b0));
      cur_freq = 0;
    end else begin
      cur_freq = fe;
    end
  endtask

  initial begin
    longint base, fs, fe, fp;
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", obs_now(), pk(0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;

    run("basic_up",   100, 130, 10, 3, 1'b0, 0, -1);
    run("clamp",      0, 25, 10, 1, 1'b0, 0, -1);
    run("no_wrap",    64'h0FFFFFF00, 64'h0FFFFFFF0, 64'h100, 1, 1'b0, 0, -1);
    run("down",       1000, 970, 15, 2, 1'b0, 0, -1);
    run("down_borrow", 64'h50, 64'h10, 64'h100, 2, 1'b0, 0, -1);
    run("single_pt",  500, 500, 7, 3, 1'b0, 0, -1);
    run("dwell0",     10, 40, 10, 0, 1'b0, 0, -1);
    run("step0",      100, 200, 0, 2, 1'b0, 0, -1);
    run("repeat",     64'h0147AEB8, 64'h028F5C70, 64'h0147AEB8, 4, 1'b1, 22, -1);

    // start and abort together in IDLE: abort wins, nothing changes
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("start_abort", obs_now(), pk(cur_freq, 1'b0, 1'b0, 1'b0));
    start = 1'b0;
    @(negedge clk);
    check("abort_idle", obs_now(), pk(cur_freq, 1'b0, 1'b0, 1'b0));
    abort = 1'b0;

    run("basic_pre", 100, 130, 10, 3, 1'b0, 0, -1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_after_done", obs_now(), pk(cur_freq, 1'b0, 1'b0, 1'b0));
    abort = 1'b0;

    run("mid_reset", 100, 400, 10, 3, 1'b0, 0, 5);
    run("after_reset", 100, 130, 10, 3, 1'b0, 0, -1);

    for (int t = 0; t < 24; t++) begin
      base = ($urandom_range(0, 1) == 1) ? 64'h0FFFF0000 : 64'h0;
      fs = base + longint'($urandom_range(0, 65535));
      fe = base + longint'($urandom_range(0, 65535));
      fp = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(2000, 40000));
      run("random", fs, fe, fp, int'($urandom_range(0, 4)), 1'b0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
